cardinal_nic: RTL and testbench
===============================

Name: cardinal_nic

Overview:
Network interface controller between one Cardinal CPU's NIC port and its ring router inside cardinal_cmp; one instance per node, four per CMP.
Holds a one-entry input channel buffer (router->CPU) and a one-entry output channel buffer (CPU->router), each with a status flag.
The CPU accesses the NIC as a 4-word register space. The router side uses a valid/ready handshake gated by the ring's virtual-channel polarity.

Parameters:
DATA_WIDTH, 64, packet/register width, bit 0 is MSB ([0:DATA_WIDTH-1] ordering)
ADDR_WIDTH, 2, NIC register address width
VC_BIT, 0, packet bit index holding the virtual-channel bit

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
addr  in  [0:1]  CPU register select: 00 input buf, 01 input status, 10 output buf, 11 output status
d_in  in  [0:63]  CPU write data
d_out  out  [0:63]  CPU read data
nicEn  in  1  CPU access enable
nicWrEn  in  1  CPU write enable (valid only with nicEn)
net_si  in  1  router has packet for NIC
net_ri  out  1  NIC input buffer can accept
net_di  in  [0:63]  packet from router
net_so  out  1  NIC presents packet to router
net_ro  in  1  router can accept packet
net_do  out  [0:63]  packet to router
net_polarity  in  1  current ring polarity (even/odd VC phase)

Behaviour:
- Reset (reset==0 at clk edge): in_buf=0, in_full=0, out_buf=0, out_full=0. Outputs then read d_out=0, net_ri=1, net_so=0, net_do=0. Reset overrides any concurrent CPU or network transfer.
- CPU read: combinational when nicEn=1 and nicWrEn=0.
  - addr 00 -> in_buf; 01 -> {63'b0,in_full}; 10 -> out_buf; 11 -> {63'b0,out_full}. Status sits in bit 63.
  - nicEn=0 or nicWrEn=1 -> d_out=0.
- Input consume: a read of addr 00 clears in_full at that edge. The buffer value is retained. Reading 00 while empty returns the stale in_buf and changes nothing.
- Input fill: net_ri = ~in_full. If net_si and net_ri are both 1 at an edge, in_buf<=net_di and in_full<=1.
  - A packet arriving in the same cycle the CPU drains a full buffer is not accepted, because net_ri=0 in that cycle.
- Output fill: CPU write to addr 10 with out_full=0 loads out_buf<=d_in and sets out_full<=1.
  - A write to 10 while out_full=1 is dropped silently.
  - Writes to 00, 01 and 11 are ignored.
- Output drain: net_so = out_full & net_ro & (out_buf[VC_BIT]==net_polarity), combinational. net_do = out_buf at all times.
  - On an edge with net_so=1, out_full<=0.
  - A CPU write to 10 in the same cycle as a drain is dropped, since the CPU saw out_full=1.
- Status flags change only at clk edges. Latency: net->CPU visible 1 cycle after handshake; CPU write->net_so eligible the next cycle.
- Both channels operate independently and concurrently.

Decomposition:
- Shared package cardinal_pkg: DATA_WIDTH, NIC address constants (ADDR_IBUF=2'b00, ADDR_ISTAT=2'b01, ADDR_OBUF=2'b10, ADDR_OSTAT=2'b11), VC_BIT, status-bit index 63.
- One natural sub-module, cardinal_nic_buf: a one-entry buffer with load/clear/full. Instantiated twice, once for input and once for output.

Test Plan:
- Reset held 3 cycles with net_si=1 and a CPU write to 10 -> after release: net_ri=1, net_so=0, out_full=0, reads of 01 and 11 return 0.
- net_si=1, net_di=64'h0000_0001_DEAD_BEEF -> next cycle net_ri=0 and read 01 =1. Read 00 returns DEAD_BEEF word; the following cycle read 01 =0 and net_ri=1.
- CPU writes 64'h8000_0000_0000_00AA (VC=1), net_ro=1, net_polarity=0 -> net_so stays 0. Flip polarity to 1 -> net_so=1 for exactly one cycle, then read 11 =0.
- Output full, CPU writes 64'h1234 to 10 -> dropped; net_do keeps the original packet until drained.
- Input full and net_si held 1 while the CPU reads 00 -> second packet accepted one cycle after the drain, not in the same cycle.
- Simultaneous input fill and output drain in one cycle -> both flags update correctly (in_full=1, out_full=0).

Source files
------------

// File: rtl/cardinal_pkg.sv
// Shared constants for the Cardinal NIC: widths, register map and packet field positions.
package cardinal_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 2;
    localparam int VC_BIT     = 0;
    localparam int STAT_BIT   = 63;

    localparam logic [ADDR_WIDTH-1:0] ADDR_IBUF  = 2'b00;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ISTAT = 2'b01;
    localparam logic [ADDR_WIDTH-1:0] ADDR_OBUF  = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] ADDR_OSTAT = 2'b11;

    // Status registers read back as a zero word with the flag in the least significant bit.
    function automatic logic [0:DATA_WIDTH-1] status_word(input logic flag);
        logic [0:DATA_WIDTH-1] w;
        w           = {DATA_WIDTH{1'b0}};
        w[STAT_BIT] = flag;
        return w;
    endfunction

endpackage

// File: rtl/cardinal_nic_buf.sv
// One-entry packet buffer with a full flag; load wins over clear, and the data
// word is retained after clear so stale reads return the last packet.
module cardinal_nic_buf
    import cardinal_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic [0:DATA_WIDTH-1] data_i,
    output logic [0:DATA_WIDTH-1] data_o,
    output logic                  full_o
);

    logic [0:DATA_WIDTH-1] data_q, data_d;
    logic                  full_q, full_d;

    // Next-state selection for the buffer word and its flag.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end else if (clear_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= {DATA_WIDTH{1'b0}};
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: CPU-visible 4-word register space bridging one input and one
// output packet buffer to the ring router's polarity-gated valid/ready ports.
module cardinal_nic
    import cardinal_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ADDR_WIDTH-1] addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    logic                  cpu_rd_s, cpu_wr_s;
    logic                  in_load_s, in_clear_s, in_full_s;
    logic                  out_load_s, out_full_s, net_so_s;
    logic [0:DATA_WIDTH-1] in_buf_s, out_buf_s;
    logic [0:DATA_WIDTH-1] d_out_s;

    assign cpu_rd_s = nicEn & ~nicWrEn;
    assign cpu_wr_s = nicEn & nicWrEn;

    // A drain and an arrival never coincide: net_ri is low whenever the CPU can drain.
    assign in_load_s  = net_si & ~in_full_s;
    assign in_clear_s = cpu_rd_s & (addr == ADDR_IBUF) & in_full_s;

    assign out_load_s = cpu_wr_s & (addr == ADDR_OBUF) & ~out_full_s;
    assign net_so_s   = out_full_s & net_ro & (out_buf_s[VC_BIT] == net_polarity);

    cardinal_nic_buf u_in_buf (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (in_load_s),
        .clear_i (in_clear_s),
        .data_i  (net_di),
        .data_o  (in_buf_s),
        .full_o  (in_full_s)
    );

    cardinal_nic_buf u_out_buf (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (out_load_s),
        .clear_i (net_so_s),
        .data_i  (d_in),
        .data_o  (out_buf_s),
        .full_o  (out_full_s)
    );

    // CPU read mux; any non-read cycle returns zero.
    always_comb begin
        d_out_s = {DATA_WIDTH{1'b0}};
        if (cpu_rd_s) begin
            case (addr)
                ADDR_IBUF:  d_out_s = in_buf_s;
                ADDR_ISTAT: d_out_s = status_word(in_full_s);
                ADDR_OBUF:  d_out_s = out_buf_s;
                ADDR_OSTAT: d_out_s = status_word(out_full_s);
                default:    d_out_s = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            d_out_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign d_out  = d_out_s;
    assign net_ri = ~in_full_s;
    assign net_so = net_so_s;
    assign net_do = out_buf_s;

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed plus randomized bench for cardinal_nic, checked against a
// transaction-level model of the two one-entry channels.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in, d_out, net_di, net_do;
    logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

    int tests  = 0;
    int failed = 0;

    // Reference state: what the CPU and router would each believe is held.
    logic [63:0] m_in_buf, m_out_buf;
    bit          m_in_full, m_out_full;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_so();
        return m_out_full && net_ro && (m_out_buf[63] == net_polarity);
    endfunction

    function automatic logic [63:0] model_dout();
        if (!(nicEn && !nicWrEn)) return 64'd0;
        case (addr)
            2'd0:    return m_in_buf;
            2'd1:    return {63'd0, m_in_full};
            2'd2:    return m_out_buf;
            default: return {63'd0, m_out_full};
        endcase
    endfunction

    // Apply one cycle of inputs and check the combinational outputs before the edge.
    task automatic step(input bit en, input bit wr, input logic [1:0] a, input logic [63:0] din,
                        input bit si, input logic [63:0] di, input bit ro, input bit pol);
        nicEn = en; nicWrEn = wr; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
        #1;
        check("d_out",  d_out,          model_dout());
        check("net_ri", {63'd0, net_ri}, {63'd0, !m_in_full});
        check("net_so", {63'd0, net_so}, {63'd0, model_so()});
        check("net_do", net_do,         m_out_buf);
    endtask

    // Advance one clock and apply the channel rules to the model.
    task automatic tick();
        bit so;
        so = model_so();
        @(posedge clk);
        if (!reset) begin
            m_in_buf = 64'd0; m_in_full = 1'b0; m_out_buf = 64'd0; m_out_full = 1'b0;
        end else begin
            if (net_si && !m_in_full) begin
                m_in_buf = net_di; m_in_full = 1'b1;
            end else if (nicEn && !nicWrEn && addr == 2'd0) begin
                m_in_full = 1'b0;
            end
            if (so) m_out_full = 1'b0;
            else if (nicEn && nicWrEn && addr == 2'd2 && !m_out_full) begin
                m_out_buf = d_in; m_out_full = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        logic [63:0] p1, p2;
        m_in_buf = 64'd0; m_out_buf = 64'd0; m_in_full = 1'b0; m_out_full = 1'b0;
        nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'd0; d_in = 64'd0;
        net_si = 1'b0; net_di = 64'd0; net_ro = 1'b0; net_polarity = 1'b0;

        // Reset held 3 cycles while both sides try to transfer.
        reset = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = 64'h5A5A_5A5A_5A5A_5A5A;
        net_si = 1'b1; net_di = 64'hFFFF_0000_FFFF_0000;
        repeat (3) tick();
        reset = 1'b1;
        step(1'b1, 1'b0, 2'd1, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        check("rst_istat", d_out, 64'd0);
        check("rst_ri", {63'd0, net_ri}, 64'd1);
        check("rst_so", {63'd0, net_so}, 64'd0);
        check("rst_do", net_do, 64'd0);
        tick();
        step(1'b1, 1'b0, 2'd3, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        check("rst_ostat", d_out, 64'd0);
        tick();

        // Router delivers a packet; CPU sees it next cycle and consumes it.
        p1 = 64'h0000_0001_DEAD_BEEF;
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, p1, 1'b0, 1'b0);
        tick();
        step(1'b1, 1'b0, 2'd1, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        check("in_stat_full", d_out, 64'd1);
        check("in_ri_low", {63'd0, net_ri}, 64'd0);
        tick();
        step(1'b1, 1'b0, 2'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        check("in_read", d_out, p1);
        tick();
        step(1'b1, 1'b0, 2'd1, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        check("in_stat_empty", d_out, 64'd0);
        check("in_ri_high", {63'd0, net_ri}, 64'd1);
        tick();

        // VC=1 packet waits for matching polarity, then drains for one cycle.
        step(1'b1, 1'b1, 2'd2, 64'h8000_0000_0000_00AA, 1'b0, 64'd0, 1'b1, 1'b0);
        tick();
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        check("vc_block", {63'd0, net_so}, 64'd0);
        tick();
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1);
        check("vc_send", {63'd0, net_so}, 64'd1);
        check("vc_do", net_do, 64'h8000_0000_0000_00AA);
        tick();
        step(1'b1, 1'b0, 2'd3, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1);
        check("vc_once", {63'd0, net_so}, 64'd0);
        check("vc_ostat", d_out, 64'd0);
        tick();

        // Write into a full output buffer is dropped.
        step(1'b1, 1'b1, 2'd2, 64'h0000_0000_0000_5555, 1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        step(1'b1, 1'b1, 2'd2, 64'h0000_0000_0000_1234, 1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        check("drop_do", net_do, 64'h0000_0000_0000_5555);
        check("drop_so", {63'd0, net_so}, 64'd1);
        tick();

        // Held net_si during a drain: second packet lands one cycle later.
        p1 = 64'h1111_2222_3333_4444;
        p2 = 64'hAAAA_BBBB_CCCC_DDDD;
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, p1, 1'b0, 1'b0);
        tick();
        step(1'b1, 1'b0, 2'd0, 64'd0, 1'b1, p2, 1'b0, 1'b0);
        check("hold_read1", d_out, p1);
        check("hold_ri_low", {63'd0, net_ri}, 64'd0);
        tick();
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, p2, 1'b0, 1'b0);
        check("hold_ri_high", {63'd0, net_ri}, 64'd1);
        tick();
        step(1'b1, 1'b0, 2'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        check("hold_read2", d_out, p2);
        tick();

        // Simultaneous input fill and output drain.
        step(1'b1, 1'b1, 2'd2, 64'h0000_0000_0000_0077, 1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
        tick();
        step(1'b1, 1'b0, 2'd1, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        check("both_istat", d_out, 64'd1);
        tick();
        step(1'b1, 1'b0, 2'd3, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        check("both_ostat", d_out, 64'd0);
        tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 49) != 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, $urandom_range(0, 1) == 1, {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            tick();
        end
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
